// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared core constants, opcode values and fetch FSM state type
package riscv_pkg;

   localparam int          XLEN      = 32;
   localparam logic [31:0] NOP_INSTR = 32'h00000013;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - instruction buffer FIFO with clear and combinational head
module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 64
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic [WIDTH-1:0]       data,
   input  logic                   pop,
   input  logic                   clear,
   output logic [WIDTH-1:0]       head,
   output logic [$clog2(DEPTH):0] count
);

   localparam int             AW   = $clog2(DEPTH);
   localparam logic [AW:0]    FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic             do_pop;
   logic             do_push;

   assign do_pop  = pop && (count != '0);
   assign do_push = push && !clear;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // The fetch credit scheme must never let a response land in a full buffer.
   assert property (@(posedge clk) disable iff (reset) do_push |-> (count != FULL || do_pop));

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC owner, imem requester and instruction buffer for decode
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirect raises a sticky fetch_fault and stalls fetch.
module instr_fetch_unit
   import riscv_pkg::*;
#(
   parameter int               XLEN       = riscv_pkg::XLEN,
   parameter logic [XLEN-1:0]  RESET_PC   = '0,
   parameter int               FIFO_DEPTH = 2
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [31:0]     instr,
   output logic [XLEN-1:0] instr_pc,
   output logic [6:0]      op,
   output logic [2:0]      funct3,
   output logic            funct7b5,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_target,
   output logic            fetch_fault
);

   localparam int          CW      = $clog2(FIFO_DEPTH) + 1;
   localparam int          DW      = 32 + XLEN;
   localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

   fetch_state_t    state, state_next;
   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] resp_pc;
   logic [CW-1:0]   outstanding, out_next;
   logic [CW-1:0]   discard, discard_next;
   logic [CW-1:0]   count;
   logic            handshake, resp, push;
   logic            fault, fault_next;
   logic [DW-1:0]   head;

   assign handshake    = imem_req & imem_gnt;
   assign resp         = imem_rvalid && (outstanding != '0);
   assign out_next     = outstanding + CW'(handshake) - CW'(resp);
   assign discard_next = discard - CW'(resp);
   assign push         = resp && (state == RUN) && !redirect;
   // In RUN every in-flight request belongs to the current sequential stream.
   assign resp_pc      = fetch_pc - (XLEN'(outstanding) << 2);

`ifdef FETCH_MISALIGN_TRAP_EN
   assign fault_next = redirect ? (redirect_target[1:0] != 2'b00) : fault;
`else
   assign fault_next = 1'b0;
`endif

   always_comb begin
      state_next = state;
      imem_req   = 1'b0;
      case (state)
         BOOT:  state_next = RUN;
         RUN: begin
            imem_req = !fault && (({1'b0, outstanding} + {1'b0, count}) < DEPTH_W);
            if (redirect && out_next != '0)
               state_next = FLUSH;
         end
         FLUSH: begin
            if (discard_next == '0)
               state_next = RUN;
         end
         default: state_next = BOOT;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= BOOT;
         fetch_pc    <= RESET_PC;
         outstanding <= '0;
         discard     <= '0;
         fault       <= 1'b0;
      end else begin
         state       <= state_next;
         outstanding <= out_next;
         fault       <= fault_next;
         if (redirect)
            fetch_pc <= redirect_target & ~XLEN'(3);
         else if (handshake)
            fetch_pc <= fetch_pc + XLEN'(4);
         if (state == RUN && redirect)
            discard <= out_next;
         else if (state == FLUSH)
            discard <= discard_next;
      end
   end

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DW)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .data  ({imem_rdata[31:0], resp_pc}),
      .pop   (instr_ready),
      .clear (redirect),
      .head  (head),
      .count (count)
   );

   assign imem_addr   = fetch_pc;
   assign instr_valid = (count != '0);
   assign instr       = instr_valid ? head[DW-1:XLEN] : NOP_INSTR;
   assign instr_pc    = instr_valid ? head[XLEN-1:0] : '0;
   assign op          = instr[6:0];
   assign funct3      = instr[14:12];
   assign funct7b5    = instr[30];
   assign fetch_fault = fault;

endmodule
